// File: rtl/ddr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr_arb_pkg
// Description : Shared constants for the DDR burst arbiter: default bus
//               widths, FSM state encodings and grant codes.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr_arb_pkg;

    localparam int c_ADDR_WIDTH_DEF = 28;
    localparam int c_DATA_WIDTH_DEF = 128;
    localparam int c_LEN_WIDTH      = 10;

    // Arbiter FSM states
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ISSUE   = 2'd1;
    localparam logic [1:0] c_ST_BUSY    = 2'd2;
    localparam logic [1:0] c_ST_RELEASE = 2'd3;

    // Grant codes; bit 0 distinguishes read (1) from write (0), bit 1 the channel
    localparam logic [1:0] c_GNT_CH0_WR = 2'd0;
    localparam logic [1:0] c_GNT_CH0_RD = 2'd1;
    localparam logic [1:0] c_GNT_CH1_WR = 2'd2;
    localparam logic [1:0] c_GNT_CH1_RD = 2'd3;

    // True when the grant code refers to a read port
    function automatic logic gnt_is_rd(input logic [1:0] gnt);
        return gnt[0];
    endfunction

endpackage : ddr_arb_pkg
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational 4-way round-robin picker. The search starts at
//               the requester after the last grant and wraps modulo 4.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_last_grant,
    output logic [1:0] o_winner,
    output logic       o_valid
);

    logic [1:0] w_idx;

    // Walk the four slots starting at last_grant+1; the first active one wins
    always_comb begin
        o_winner = 2'd0;
        o_valid  = 1'b0;
        w_idx    = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            w_idx = i_last_grant + 2'(i);
            if (!o_valid && i_req[w_idx]) begin
                o_winner = w_idx;
                o_valid  = 1'b1;
            end
        end
    end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/ddr_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ddr_burst_arbiter
// Description : Round-robin arbiter granting one of four burst requesters
//               (ch0/ch1 x write/read) access to a single DDR controller
//               port. Exactly one burst is outstanding at any time.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_burst_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEF
) (
    input  logic                   ui_clk,
    input  logic                   ui_clk_sync_rst,
    input  logic                   init_calib_complete,
    // channel 0 write
    input  logic                   ch0_wr_burst_req,
    input  logic [9:0]             ch0_wr_burst_len,
    input  logic [ADDR_WIDTH-1:0]  ch0_wr_burst_addr,
    input  logic [DATA_WIDTH-1:0]  ch0_wr_burst_data,
    output logic                   ch0_wr_burst_data_req,
    output logic                   ch0_wr_burst_finish,
    // channel 0 read
    input  logic                   ch0_rd_burst_req,
    input  logic [9:0]             ch0_rd_burst_len,
    input  logic [ADDR_WIDTH-1:0]  ch0_rd_burst_addr,
    output logic                   ch0_rd_burst_data_valid,
    output logic                   ch0_rd_burst_finish,
    output logic [DATA_WIDTH-1:0]  ch0_rd_burst_data,
    // channel 1 write
    input  logic                   ch1_wr_burst_req,
    input  logic [9:0]             ch1_wr_burst_len,
    input  logic [ADDR_WIDTH-1:0]  ch1_wr_burst_addr,
    input  logic [DATA_WIDTH-1:0]  ch1_wr_burst_data,
    output logic                   ch1_wr_burst_data_req,
    output logic                   ch1_wr_burst_finish,
    // channel 1 read
    input  logic                   ch1_rd_burst_req,
    input  logic [9:0]             ch1_rd_burst_len,
    input  logic [ADDR_WIDTH-1:0]  ch1_rd_burst_addr,
    output logic                   ch1_rd_burst_data_valid,
    output logic                   ch1_rd_burst_finish,
    output logic [DATA_WIDTH-1:0]  ch1_rd_burst_data,
    // controller write port
    output logic                   wr_burst_req,
    output logic [9:0]             wr_burst_len,
    output logic [ADDR_WIDTH-1:0]  wr_burst_addr,
    output logic [DATA_WIDTH-1:0]  wr_burst_data,
    input  logic                   wr_burst_data_req,
    input  logic                   wr_burst_finish,
    // controller read port
    output logic                   rd_burst_req,
    output logic [9:0]             rd_burst_len,
    output logic [ADDR_WIDTH-1:0]  rd_burst_addr,
    input  logic                   rd_burst_data_valid,
    input  logic                   rd_burst_finish,
    input  logic [DATA_WIDTH-1:0]  rd_burst_data,
    // status
    output logic [1:0]             grant,
    output logic                   busy
);

    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic [1:0]             r_grant;
    logic [1:0]             r_last_grant;
    logic                   r_wr_req;
    logic [9:0]             r_wr_len;
    logic [ADDR_WIDTH-1:0]  r_wr_addr;
    logic                   r_rd_req;
    logic [9:0]             r_rd_len;
    logic [ADDR_WIDTH-1:0]  r_rd_addr;

    logic [3:0]             w_req;
    logic [1:0]             w_pick;
    logic                   w_pick_valid;
    logic                   w_start;
    logic                   w_ctrl_fin;
    logic [9:0]             w_win_len;
    logic [ADDR_WIDTH-1:0]  w_win_addr;

    // Request vector bit order matches the grant codes
    assign w_req = {ch1_rd_burst_req, ch1_wr_burst_req, ch0_rd_burst_req, ch0_wr_burst_req};

    rr_pick4 u_rr_pick4 (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_winner     (w_pick),
        .o_valid      (w_pick_valid)
    );

    // A new burst may only start from IDLE once calibration is done
    assign w_start    = (r_state == c_ST_IDLE) && init_calib_complete && w_pick_valid;
    // Finish from the controller port that matches the current owner
    assign w_ctrl_fin = gnt_is_rd(r_grant) ? rd_burst_finish : wr_burst_finish;

    // Select the winning requester's length and address for latching
    always_comb begin
        w_win_len  = ch0_wr_burst_len;
        w_win_addr = ch0_wr_burst_addr;
        case (w_pick)
            c_GNT_CH0_RD: begin w_win_len = ch0_rd_burst_len; w_win_addr = ch0_rd_burst_addr; end
            c_GNT_CH1_WR: begin w_win_len = ch1_wr_burst_len; w_win_addr = ch1_wr_burst_addr; end
            c_GNT_CH1_RD: begin w_win_len = ch1_rd_burst_len; w_win_addr = ch1_rd_burst_addr; end
            default:      begin w_win_len = ch0_wr_burst_len; w_win_addr = ch0_wr_burst_addr; end
        endcase
    end

    // State register
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:    if (w_start) w_next_state = c_ST_ISSUE;
            c_ST_ISSUE:   w_next_state = c_ST_BUSY;
            c_ST_BUSY:    if (w_ctrl_fin) w_next_state = c_ST_RELEASE;
            c_ST_RELEASE: w_next_state = c_ST_IDLE;
            default:      w_next_state = c_ST_IDLE;
        endcase
    end

    // Burst command registers: latched on the IDLE->ISSUE edge so the
    // controller req rises one cycle after IDLE sees the request, then held
    // stable until the controller finishes
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            r_grant      <= c_GNT_CH0_WR;
            r_last_grant <= c_GNT_CH1_RD;
            r_wr_req     <= 1'b0;
            r_wr_len     <= '0;
            r_wr_addr    <= '0;
            r_rd_req     <= 1'b0;
            r_rd_len     <= '0;
            r_rd_addr    <= '0;
        end else begin
            if (w_start) begin
                r_grant <= w_pick;
                if (gnt_is_rd(w_pick)) begin
                    r_rd_req  <= 1'b1;
                    r_rd_len  <= w_win_len;
                    r_rd_addr <= w_win_addr;
                end else begin
                    r_wr_req  <= 1'b1;
                    r_wr_len  <= w_win_len;
                    r_wr_addr <= w_win_addr;
                end
            end
            if ((r_state == c_ST_BUSY) && w_ctrl_fin) begin
                r_wr_req <= 1'b0;
                r_rd_req <= 1'b0;
            end
            if (r_state == c_ST_RELEASE) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Output decode: handshakes are forwarded to the owner only while BUSY
    always_comb begin
        busy                    = 1'b0;
        ch0_wr_burst_data_req   = 1'b0;
        ch0_wr_burst_finish     = 1'b0;
        ch0_rd_burst_data_valid = 1'b0;
        ch0_rd_burst_finish     = 1'b0;
        ch1_wr_burst_data_req   = 1'b0;
        ch1_wr_burst_finish     = 1'b0;
        ch1_rd_burst_data_valid = 1'b0;
        ch1_rd_burst_finish     = 1'b0;
        if ((r_state == c_ST_ISSUE) || (r_state == c_ST_BUSY)) begin
            busy = 1'b1;
        end
        if (r_state == c_ST_BUSY) begin
            case (r_grant)
                c_GNT_CH0_WR: begin
                    ch0_wr_burst_data_req = wr_burst_data_req;
                    ch0_wr_burst_finish   = wr_burst_finish;
                end
                c_GNT_CH0_RD: begin
                    ch0_rd_burst_data_valid = rd_burst_data_valid;
                    ch0_rd_burst_finish     = rd_burst_finish;
                end
                c_GNT_CH1_WR: begin
                    ch1_wr_burst_data_req = wr_burst_data_req;
                    ch1_wr_burst_finish   = wr_burst_finish;
                end
                default: begin
                    ch1_rd_burst_data_valid = rd_burst_data_valid;
                    ch1_rd_burst_finish     = rd_burst_finish;
                end
            endcase
        end
    end

    assign wr_burst_req      = r_wr_req;
    assign wr_burst_len      = r_wr_len;
    assign wr_burst_addr     = r_wr_addr;
    assign rd_burst_req      = r_rd_req;
    assign rd_burst_len      = r_rd_len;
    assign rd_burst_addr     = r_rd_addr;
    assign grant             = r_grant;

    // Write data follows the channel bit of the grant; read data is shared
    assign wr_burst_data     = r_grant[1] ? ch1_wr_burst_data : ch0_wr_burst_data;
    assign ch0_rd_burst_data = rd_burst_data;
    assign ch1_rd_burst_data = rd_burst_data;

endmodule : ddr_burst_arbiter
`default_nettype wire

// File: doc/ddr_burst_arbiter.md
DDR_BURST_ARBITER -- requirements
Module: ddr_burst_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 28, is the burst address width.
REQ-002 Parameter DATA_WIDTH, default 128, is the burst data width.
REQ-003 ui_clk  in  1  is the single clock; all logic runs on its rising edge.
REQ-004 ui_clk_sync_rst  in  1  is the reset: asynchronous, active-high.
REQ-005 init_calib_complete  in  1  is DDR calibration done; no grant is issued while it is 0.
REQ-006 chN_wr_burst_req / _len[9:0] / _addr[ADDR_WIDTH] / _data[DATA_WIDTH]  in, and chN_wr_burst_data_req / _finish  out, for N=0,1, form the requester write ports.
REQ-007 chN_rd_burst_req / _len[9:0] / _addr  in, and chN_rd_burst_data_valid / _finish  out / chN_rd_burst_data[DATA_WIDTH]  out, for N=0,1, form the requester read ports.
REQ-008 wr_burst_req / wr_burst_len / wr_burst_addr / wr_burst_data  out, and wr_burst_data_req / wr_burst_finish  in, form the controller write port.
REQ-009 rd_burst_req / rd_burst_len / rd_burst_addr  out, and rd_burst_data_valid / rd_burst_finish / rd_burst_data  in, form the controller read port.
REQ-010 grant[1:0]  out  2  gives the current owner: 0=ch0 wr, 1=ch0 rd, 2=ch1 wr, 3=ch1 rd.
REQ-011 busy  out  1  is high while a burst is owned.

Function
REQ-012 The FSM SHALL have states IDLE, ISSUE, BUSY and RELEASE.
REQ-013 IDLE->ISSUE SHALL occur when init_calib_complete=1 and any of the 4 requests is high; the winner is latched into grant.
REQ-014 Arbitration SHALL be round-robin: the search starts at (last_grant+1) mod 4; after reset last_grant=3, so ch0 wr wins first.
REQ-015 ISSUE SHALL latch the winner's len and addr and drive them to the controller port, assert the matching controller req, and move to BUSY next cycle; controller req is high 1 cycle after IDLE sees the request.
REQ-016 In BUSY, the controller req/len/addr SHALL stay constant until the controller finish.
REQ-017 Controller finish in BUSY SHALL deassert controller req on the next edge, pulse the owner's chN_*_finish for exactly 1 cycle (combinational pass-through), and move to RELEASE.
REQ-018 RELEASE SHALL last 1 cycle, update last_grant, and return to IDLE; the requester drops req during this cycle.
REQ-019 wr_burst_data SHALL be a combinational mux of chN_wr_burst_data selected by grant; wr_burst_data_req SHALL route only to the write owner; non-owners see 0.
REQ-020 rd_burst_data SHALL fan out to both channels; rd_burst_data_valid SHALL route only to the read owner.
REQ-021 Only one burst (read or write) SHALL be outstanding at any time.
REQ-022 A request dropped mid-BUSY SHALL be ignored; the burst completes normally.
REQ-023 Controller finish or data_req/valid outside BUSY SHALL be ignored and produce no channel pulses.
REQ-024 init_calib_complete falling in BUSY SHALL NOT abort the burst; only IDLE is gated by it.
REQ-025 Burst len 0 SHALL be forwarded unchanged; the arbiter does no length checking.

Reset
REQ-026 On ui_clk_sync_rst=1 the block SHALL enter IDLE asynchronously, with wr_burst_req=rd_burst_req=0, wr/rd_burst_len=0, wr/rd_burst_addr=0, grant=0, busy=0, last_grant=3, and all channel finish/data_req/valid outputs 0.
REQ-027 Reset mid-burst SHALL drop controller req immediately; no finish pulse is generated.

Structure
REQ-028 State encodings and grant codes SHALL live in shared package ddr_arb_pkg, together with the ADDR_WIDTH/DATA_WIDTH defaults.
REQ-029 The round-robin priority picker SHALL be a sub-module rr_pick4 (4 requests, last grant in, 2-bit winner plus valid out, combinational).

Verification
REQ-030 After reset, ch0 wr requests len=128, addr=0 -> wr_burst_req rises 1 cycle later, 128 data_req pulses reach ch0 only, and ch0_wr_burst_finish pulses once.
REQ-031 All 4 requests held continuously -> grant sequence 0,1,2,3,0 with exactly one burst outstanding at a time.
REQ-032 ch1 rd len=64, addr=0x1000 -> rd_burst_addr=0x1000; 64 valids reach ch1 only; ch0_rd_burst_data_valid stays 0.
REQ-033 Reset asserted during BUSY at beat 10 -> all reqs go 0 immediately, no finish pulse, and the first post-reset grant is 0.
REQ-034 init_calib_complete=0 with requests pending -> no controller req; after it rises -> grant issued within 2 cycles.
REQ-035 Spurious controller finish in IDLE -> no channel finish pulse and state stays IDLE.
